add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/add_arbiter.sv
// add_arbiter: two-requester round-robin arbiter time-sharing one carry-select add/sub unit.
// Each operation walks IDLE -> EXEC -> DONE and is held in DONE until the consumer takes it.
module add_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic        req_sub0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic        req_sub1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [31:0] res_out,
  output logic        res_co,
  output logic        res_ovf,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic rr_ptr, grant, accept, op_sub, op_id, co, ovf;
  logic [31:0] op_a, op_b, sum;
  assign grant = &req_valid ? rr_ptr : req_valid[1];
  assign req_ready = (reset_n && state == IDLE && |req_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign accept = |req_ready;
  assign res_valid = state == DONE;
  assign busy = state != IDLE;
  // Subtraction is a + ~b + 1, so the adder only ever sees registered operands.
  csel_adder u_add (
    .a   (op_a),
    .b   (op_sub ? ~op_b : op_b),
    .ci  (op_sub),
    .out (sum),
    .co  (co),
    .ovf (ovf)
  );
  always_comb begin
    state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
               state == EXEC ? DONE :
               state == DONE ? (res_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr  <= RR_INIT;
      op_a    <= '0;
      op_b    <= '0;
      op_sub  <= 1'b0;
      op_id   <= 1'b0;
      res_id  <= 1'b0;
      res_out <= '0;
      res_co  <= 1'b0;
      res_ovf <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= grant ? req_a1 : req_a0;
        op_b   <= grant ? req_b1 : req_b0;
        op_sub <= grant ? req_sub1 : req_sub0;
        op_id  <= grant;
      end
      if (state == EXEC) begin
        res_out <= sum;
        res_co  <= co;
        res_ovf <= ovf;
        res_id  <= op_id;
      end
      if (state == DONE && res_ready) rr_ptr <= ~res_id;
    end
  end
endmodule

// csel_adder: 32-bit carry-select adder; upper half precomputed for both carries.
module csel_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] out,
  output logic        co,
  output logic        ovf
);
  logic [16:0] lo, hi0, hi1;
  assign lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'b0, ci};
  assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
  assign hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
  assign {co, out[31:16]} = lo[16] ? hi1 : hi0;
  assign out[15:0] = lo[15:0];
  assign ovf = (a[31] == b[31]) && (out[31] != a[31]);
endmodule
